// File: rtl/alu_issue_if.sv
// Shared ALU/comparator codes and the issue-stage bus: fetch side (ids_*),
// execute side (exs_*), plus writeback retire and flush.
package alu_issue_pkg;
  localparam logic [3:0] ALUOP_ADD  = 4'd0;
  localparam logic [3:0] ALUOP_SUB  = 4'd1;
  localparam logic [3:0] ALUOP_SLL  = 4'd2;
  localparam logic [3:0] ALUOP_SLT  = 4'd3;
  localparam logic [3:0] ALUOP_SLTU = 4'd4;
  localparam logic [3:0] ALUOP_XOR  = 4'd5;
  localparam logic [3:0] ALUOP_SRL  = 4'd6;
  localparam logic [3:0] ALUOP_SRA  = 4'd7;
  localparam logic [3:0] ALUOP_OR   = 4'd8;
  localparam logic [3:0] ALUOP_AND  = 4'd9;
  localparam logic [3:0] ALUOP_MOV  = 4'd10;

  // Condition codes share the BRANCH funct3 encoding so decode is a straight copy.
  localparam logic [2:0] ALUCOND_EQ  = 3'b000;
  localparam logic [2:0] ALUCOND_NE  = 3'b001;
  localparam logic [2:0] ALUCOND_LT  = 3'b100;
  localparam logic [2:0] ALUCOND_GE  = 3'b101;
  localparam logic [2:0] ALUCOND_LTU = 3'b110;
  localparam logic [2:0] ALUCOND_GEU = 3'b111;

  typedef struct packed {
    logic [31:0] left;
    logic [31:0] right;
    logic [31:0] cl;
    logic [31:0] cr;
    logic [3:0]  op;
    logic [2:0]  cop;
    logic [4:0]  rd;
    logic        wr;
    logic        br;
    logic        ill;
  } slot_t;
endpackage

interface alu_issue_if #(parameter int C_XLEN = 32);
  logic              ids_valid_i;
  logic              ids_ready_o;
  logic [31:0]       ids_ins_i;
  logic [C_XLEN-1:0] ids_pc_i;
  logic [C_XLEN-1:0] rs1_data_i;
  logic [C_XLEN-1:0] rs2_data_i;
  logic              exs_valid_o;
  logic              exs_ready_i;
  logic [C_XLEN-1:0] op_left_o;
  logic [C_XLEN-1:0] op_right_o;
  logic [3:0]        op_opcode_o;
  logic [C_XLEN-1:0] cmp_left_o;
  logic [C_XLEN-1:0] cmp_right_o;
  logic [2:0]        cmp_opcode_o;
  logic [4:0]        exs_rd_o;
  logic              exs_wr_en_o;
  logic              exs_branch_o;
  logic              exs_illegal_o;
  logic              wb_valid_i;
  logic [4:0]        wb_rd_i;
  logic              flush_i;

  modport slave (
    input  ids_valid_i, ids_ins_i, ids_pc_i, rs1_data_i, rs2_data_i,
           exs_ready_i, wb_valid_i, wb_rd_i, flush_i,
    output ids_ready_o, exs_valid_o, op_left_o, op_right_o, op_opcode_o,
           cmp_left_o, cmp_right_o, cmp_opcode_o, exs_rd_o, exs_wr_en_o,
           exs_branch_o, exs_illegal_o
  );
  modport master (
    output ids_valid_i, ids_ins_i, ids_pc_i, rs1_data_i, rs2_data_i,
           exs_ready_i, wb_valid_i, wb_rd_i, flush_i,
    input  ids_ready_o, exs_valid_o, op_left_o, op_right_o, op_opcode_o,
           cmp_left_o, cmp_right_o, cmp_opcode_o, exs_rd_o, exs_wr_en_o,
           exs_branch_o, exs_illegal_o
  );
endinterface

// File: rtl/alu_issue.sv
// RV32I decode/issue stage: decodes into an ALU/comparator bundle, holds it in
// a one-deep output slot, and stalls RAW hazards on a 32-entry busy scoreboard.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int C_XLEN_X = 5,
  parameter int C_XLEN   = 2**C_XLEN_X
) (
  input  logic        clk_i,
  input  logic        reset_i,
  alu_issue_if.slave  bus
);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [31:0] w_ins;
  logic [6:0]  w_opc, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [31:0] w_imm_i, w_imm_u, w_imm_b, w_shamt;
  slot_t       w_dec;
  logic        w_rs1_used, w_rs2_used, w_haz, w_ready, w_fire;
  logic [31:0] w_set, w_clr;
  slot_t       r_slot;
  logic        r_vld;
  logic [31:0] r_busy;

  assign w_ins   = bus.ids_ins_i;
  assign w_opc   = w_ins[6:0];
  assign w_rd    = w_ins[11:7];
  assign w_f3    = w_ins[14:12];
  assign w_rs1   = w_ins[19:15];
  assign w_rs2   = w_ins[24:20];
  assign w_f7    = w_ins[31:25];
  assign w_imm_i = {{20{w_ins[31]}}, w_ins[31:20]};
  assign w_imm_u = {w_ins[31:12], 12'b0};
  assign w_imm_b = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
  assign w_shamt = {27'b0, w_ins[24:20]};

  always_comb begin
    w_dec      = '0;
    w_dec.op   = ALUOP_ADD;
    w_dec.cop  = ALUCOND_EQ;
    w_dec.cl   = bus.rs1_data_i;
    w_dec.cr   = bus.rs2_data_i;
    w_dec.rd   = w_rd;
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    case (w_opc)
      OPC_OP: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_dec.left  = bus.rs1_data_i;
        w_dec.right = bus.rs2_data_i;
        w_dec.wr    = 1'b1;
        case (w_f3)
          3'b000: w_dec.op = w_f7[5] ? ALUOP_SUB : ALUOP_ADD;
          3'b001: w_dec.op = ALUOP_SLL;
          3'b010: w_dec.op = ALUOP_SLT;
          3'b011: w_dec.op = ALUOP_SLTU;
          3'b100: w_dec.op = ALUOP_XOR;
          3'b101: w_dec.op = w_f7[5] ? ALUOP_SRA : ALUOP_SRL;
          3'b110: w_dec.op = ALUOP_OR;
          default: w_dec.op = ALUOP_AND;
        endcase
        w_dec.ill = !((w_f7 == 7'h00) ||
                      ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
      end
      OPC_OPIMM: begin
        w_rs1_used  = 1'b1;
        w_dec.left  = bus.rs1_data_i;
        w_dec.right = w_imm_i;
        w_dec.wr    = 1'b1;
        case (w_f3)
          3'b000: w_dec.op = ALUOP_ADD;
          3'b001: begin
            w_dec.op    = ALUOP_SLL;
            w_dec.right = w_shamt;
            w_dec.ill   = (w_f7 != 7'h00);
          end
          3'b010: w_dec.op = ALUOP_SLT;
          3'b011: w_dec.op = ALUOP_SLTU;
          3'b100: w_dec.op = ALUOP_XOR;
          3'b101: begin
            w_dec.op    = w_f7[5] ? ALUOP_SRA : ALUOP_SRL;
            w_dec.right = w_shamt;
            w_dec.ill   = !((w_f7 == 7'h00) || (w_f7 == 7'h20));
          end
          3'b110: w_dec.op = ALUOP_OR;
          default: w_dec.op = ALUOP_AND;
        endcase
      end
      OPC_LUI: begin
        w_dec.op    = ALUOP_MOV;
        w_dec.right = w_imm_u;
        w_dec.wr    = 1'b1;
      end
      OPC_AUIPC: begin
        w_dec.left  = bus.ids_pc_i;
        w_dec.right = w_imm_u;
        w_dec.wr    = 1'b1;
      end
      OPC_BRANCH: begin
        w_rs1_used  = 1'b1;
        w_rs2_used  = 1'b1;
        w_dec.left  = bus.ids_pc_i;
        w_dec.right = w_imm_b;
        w_dec.cop   = w_f3;
        w_dec.br    = 1'b1;
        w_dec.ill   = (w_f3[2:1] == 2'b01);
      end
      default: w_dec.ill = 1'b1;
    endcase
    if (w_dec.ill) begin
      w_dec.wr  = 1'b0;
      w_dec.br  = 1'b0;
      w_dec.op  = ALUOP_ADD;
      w_dec.cop = ALUCOND_EQ;
    end
    if (w_rd == 5'd0) w_dec.wr = 1'b0;
  end

  // No bypass: a register retiring this cycle still reads as busy.
  assign w_haz   = (w_rs1_used && r_busy[w_rs1]) || (w_rs2_used && r_busy[w_rs2]);
  assign w_ready = !w_haz && (!r_vld || bus.exs_ready_i) && !bus.flush_i;
  assign w_fire  = bus.ids_valid_i && w_ready;

  assign w_set = (w_fire && w_dec.wr) ? (32'd1 << w_rd) : 32'd0;
  assign w_clr = ((bus.wb_valid_i && (bus.wb_rd_i != 5'd0)) ? (32'd1 << bus.wb_rd_i) : 32'd0) |
                 ((bus.flush_i && r_vld && r_slot.wr) ? (32'd1 << r_slot.rd) : 32'd0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_vld      <= 1'b0;
      r_busy     <= '0;
      r_slot     <= '0;
      r_slot.op  <= ALUOP_ADD;
      r_slot.cop <= ALUCOND_EQ;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
      if (bus.flush_i)          r_vld <= 1'b0;
      else if (w_fire) begin
        r_vld  <= 1'b1;
        r_slot <= w_dec;
      end else if (bus.exs_ready_i) r_vld <= 1'b0;
    end
  end

  assign bus.ids_ready_o   = w_ready;
  assign bus.exs_valid_o   = r_vld;
  assign bus.op_left_o     = r_slot.left;
  assign bus.op_right_o    = r_slot.right;
  assign bus.op_opcode_o   = r_slot.op;
  assign bus.cmp_left_o    = r_slot.cl;
  assign bus.cmp_right_o   = r_slot.cr;
  assign bus.cmp_opcode_o  = r_slot.cop;
  assign bus.exs_rd_o      = r_slot.rd;
  assign bus.exs_wr_en_o   = r_slot.wr;
  assign bus.exs_branch_o  = r_slot.br;
  assign bus.exs_illegal_o = r_slot.ill;
endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Decode/issue stage that produces the operand, opcode and comparator bundle consumed by the RV32I ALU.
- Accepts one instruction per cycle from fetch, with register-file read data, over a valid/ready handshake.
- Decodes OP, OP-IMM, LUI, AUIPC and BRANCH into `ALUOP_*` / `ALUCOND_*` codes from riscv_defs.v.
- Holds the result in a registered output slot; a 32-entry scoreboard stalls RAW hazards until writeback.

Parameters:
- C_XLEN_X, 5, log2 of datapath width; only 5 is legal (RV32 decode).
- C_XLEN, 2**C_XLEN_X, derived datapath width.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- reset_i  in  1  reset
- ids_valid_i  in  1  instruction/PC/register data valid
- ids_ready_o  out  1  stage accepts input this cycle
- ids_ins_i  in  32  instruction word
- ids_pc_i  in  C_XLEN  instruction PC
- rs1_data_i  in  C_XLEN  regfile read of ins[19:15]
- rs2_data_i  in  C_XLEN  regfile read of ins[24:20]
- exs_valid_o  out  1  output slot holds an instruction
- exs_ready_i  in  1  ALU/execute consumes the slot
- op_left_o  out  C_XLEN  ALU left operand
- op_right_o  out  C_XLEN  ALU right operand
- op_opcode_o  out  `ALUOP_RANGE  ALU operation
- cmp_left_o  out  C_XLEN  comparator left operand (rs1)
- cmp_right_o  out  C_XLEN  comparator right operand (rs2)
- cmp_opcode_o  out  3  comparator condition (`ALUCOND_*`)
- exs_rd_o  out  5  destination register
- exs_wr_en_o  out  1  instruction writes rd
- exs_branch_o  out  1  instruction is a conditional branch
- exs_illegal_o  out  1  undecodable instruction
- wb_valid_i  in  1  writeback retiring a register write
- wb_rd_i  in  5  register being written back
- flush_i  in  1  kill the instruction held in the output slot

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on reset_i.
- Reset values: exs_valid_o=0 and scoreboard all-clear. All other outputs = 0, except op_opcode_o=`ALUOP_ADD` and cmp_opcode_o=`ALUCOND_EQ`.
- Hazard: hazard = (rs1 used AND busy[rs1]) OR (rs2 used AND busy[rs2]). x0 is never busy.
  - rs1 is used by OP, OP-IMM and BRANCH.
  - rs2 is used by OP and BRANCH.
- Ready: ids_ready_o = !hazard AND (!exs_valid_o OR exs_ready_i) AND !flush_i.
- Accept (fire) = ids_valid_i AND ids_ready_o. The output slot loads on the next edge; latency is 1 cycle.
- Slot not accepted: if exs_valid_o=1 and exs_ready_i=0, all slot outputs hold stable.
- Consumed, no new fire: exs_valid_o drops to 0.
- Decode, by opcode ins[6:0]:
  - OP (0110011): left=rs1, right=rs2, wr_en=1. funct3 selects the op. funct7=0100000 is legal only with funct3 000 (SUB) and 101 (SRA). Any other funct7 other than 0 is illegal.
  - OP-IMM (0010011): left=rs1, right=sign-extended I-immediate, wr_en=1.
    - SLLI requires funct7=0.
    - SRLI/SRAI require funct7 of 0 / 0100000.
    - For shifts, right={27'b0, ins[24:20]}.
  - LUI: op=MOV, right={ins[31:12],12'b0}, wr_en=1.
  - AUIPC: op=ADD, left=pc, right={ins[31:12],12'b0}, wr_en=1.
  - BRANCH (1100011): op=ADD, left=pc, right=sign-extended B-immediate (target address). cmp_left=rs1, cmp_right=rs2, cmp_opcode=funct3, wr_en=0, exs_branch_o=1. funct3 010/011 are illegal.
  - Any other opcode is illegal.
- cmp_opcode for non-branches is `ALUCOND_EQ`; cmp operands are still rs1/rs2.
- Illegal instruction: exs_illegal_o=1, wr_en=0, op=`ALUOP_ADD`, scoreboard unchanged. Issue continues normally.
- wr_en with rd=0 is forced to 0.
- Scoreboard:
  - On fire with wr_en=1, set busy[rd].
  - On wb_valid_i with wb_rd_i!=0, clear busy[wb_rd_i].
  - Same register set and cleared in the same cycle: set wins.
  - No bypass: a source being cleared this cycle still stalls; issue is possible the next cycle.
- flush_i:
  - Next edge: exs_valid_o=0.
  - If the slot held a wr_en instruction, clear busy[exs_rd_o].
  - Input is blocked that cycle.
  - flush_i and exs_ready_i in the same cycle: flush wins.
  - flush_i with an empty slot: no effect.
- Reset mid-stall or with the slot full: the slot is emptied and the scoreboard cleared on the next edge.

Test Plan:
1. Reset 2 cycles -> exs_valid_o=0, ids_ready_o=1, scoreboard empty.
2. ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, exs_ready_i=1 -> next cycle: op_opcode_o=ALUOP_ADD, op_left_o=5, op_right_o=7, exs_rd_o=3, wr_en=1. Then SUB (0x402081B3) -> ALUOP_SUB.
3. ADDI x5,x0,-1 (0xFFF00293) -> op_right_o=0xFFFFFFFF, op_left_o=rs1 data. LUI x1,0x12345 (0x123450B7) -> ALUOP_MOV, op_right_o=0x12345000.
4. BEQ x1,x2,+8 (0x00208463) at pc=0x100 -> op_left_o=0x100, op_right_o=8, cmp_opcode_o=ALUCOND_EQ, exs_branch_o=1, wr_en=0. Same word with funct3=010 -> exs_illegal_o=1.
5. ADDI x1,x0,5 (0x00500093) then ADD x2,x1,x1 (0x00108133) -> ids_ready_o=0 until the cycle after wb_valid_i=1 with wb_rd_i=1; the ADD then issues. The same cycle as that writeback still stalls.
6. Slot full, exs_ready_i=0, flush_i=1 -> exs_valid_o=0 next cycle, busy[rd] cleared. A subsequent reader of that rd issues without stall.
